// File: rtl/duart_pkg.sv
// Shared encodings and defaults for the DUART receive channel.
package duart_pkg;

  localparam logic [1:0] RXEN_NONE = 2'b00;
  localparam logic [1:0] RXEN_ON   = 2'b01;
  localparam logic [1:0] RXEN_OFF  = 2'b10;

  localparam logic [2:0] CMD_RST_RX  = 3'b010;
  localparam logic [2:0] CMD_RST_ERR = 3'b100;

  localparam int RX_FIFO_DEPTH_DEF = 3;

endpackage

// File: rtl/duart_rx_channel_ctrl_if.sv
// Receiver/CPU-side signal bundle for one DUART receive channel.
// o_Ovr_Count exists only when DUART_RX_OVR_COUNT_EN is defined.
interface duart_rx_channel_ctrl_if;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic [1:0] i_Rx_En_Cmd;
  logic [2:0] i_Misc_Cmd;
  logic       i_Cmd_Wr;
  logic       i_Rd_Strobe;
  logic       i_Irq_Sel_Full;
  logic [7:0] o_Rx_Data;
  logic       o_RxRDY;
  logic       o_FFULL;
  logic       o_Overrun;
  logic       o_Rx_Enabled;
  logic       o_Rx_Irq;
`ifdef DUART_RX_OVR_COUNT_EN
  logic [7:0] o_Ovr_Count;
`endif

  modport master (
`ifdef DUART_RX_OVR_COUNT_EN
    input  o_Ovr_Count,
`endif
    output i_RX_DV, i_RX_Byte, i_Rx_En_Cmd, i_Misc_Cmd, i_Cmd_Wr,
           i_Rd_Strobe, i_Irq_Sel_Full,
    input  o_Rx_Data, o_RxRDY, o_FFULL, o_Overrun, o_Rx_Enabled, o_Rx_Irq
  );

  modport slave (
`ifdef DUART_RX_OVR_COUNT_EN
    output o_Ovr_Count,
`endif
    input  i_RX_DV, i_RX_Byte, i_Rx_En_Cmd, i_Misc_Cmd, i_Cmd_Wr,
           i_Rd_Strobe, i_Irq_Sel_Full,
    output o_Rx_Data, o_RxRDY, o_FFULL, o_Overrun, o_Rx_Enabled, o_Rx_Irq
  );
endinterface

// File: rtl/duart_rx_fifo.sv
// Receive character FIFO of arbitrary depth; caller guarantees push/pop legality.
module duart_rx_fifo #(
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    head,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointers wrap by compare so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/duart_rx_channel_ctrl.sv
// DUART receive channel controller: enable gating, RX FIFO, status, overrun, IRQ.
// Optional saturating overrun counter enabled by DUART_RX_OVR_COUNT_EN.
module duart_rx_channel_ctrl
  import duart_pkg::*;
#(
  parameter int FIFO_DEPTH = RX_FIFO_DEPTH_DEF
) (
  input  logic              i_Clock,
  input  logic              i_Rst_L,
  duart_rx_channel_ctrl_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          enabled;
  logic          overrun;
  logic [CW-1:0] count;
  logic [7:0]    head;
  logic          full;
  logic          rst_rx;
  logic          rst_err;
  logic          pop;
  logic          push;
  logic          ovr_evt;

  assign rst_rx  = bus.i_Cmd_Wr && (bus.i_Misc_Cmd == CMD_RST_RX);
  assign rst_err = bus.i_Cmd_Wr && (bus.i_Misc_Cmd == CMD_RST_ERR);
  assign full    = (count == CW'(FIFO_DEPTH));

  // Receiver reset outranks any same-cycle data movement.
  assign pop     = !rst_rx && bus.i_Rd_Strobe && (count != '0);
  assign push    = !rst_rx && bus.i_RX_DV && enabled && (!full || pop);
  assign ovr_evt = !rst_rx && bus.i_RX_DV && enabled && full && !pop;

  duart_rx_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk   (i_Clock),
    .rst_n (i_Rst_L),
    .push  (push),
    .pop   (pop),
    .flush (rst_rx),
    .din   (bus.i_RX_Byte),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      enabled <= 1'b0;
      overrun <= 1'b0;
    end else if (rst_rx) begin
      enabled <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (bus.i_Cmd_Wr && bus.i_Rx_En_Cmd == RXEN_ON)  enabled <= 1'b1;
      if (bus.i_Cmd_Wr && bus.i_Rx_En_Cmd == RXEN_OFF) enabled <= 1'b0;
      if (ovr_evt)      overrun <= 1'b1;
      else if (rst_err) overrun <= 1'b0;
    end
  end

`ifdef DUART_RX_OVR_COUNT_EN
  logic [7:0] ovr_cnt;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L)                        ovr_cnt <= 8'h00;
    else if (rst_rx)                     ovr_cnt <= 8'h00;
    else if (rst_err)                    ovr_cnt <= {7'h00, ovr_evt};
    else if (ovr_evt && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'h01;
  end

  assign bus.o_Ovr_Count = ovr_cnt;
`endif

  assign bus.o_Rx_Data    = head;
  assign bus.o_RxRDY      = (count != '0);
  assign bus.o_FFULL      = full;
  assign bus.o_Overrun    = overrun;
  assign bus.o_Rx_Enabled = enabled;
  assign bus.o_Rx_Irq     = bus.i_Irq_Sel_Full ? full : (count != '0);
endmodule

// File: tb/tb_duart_rx_channel_ctrl.sv
// Self-checking bench for duart_rx_channel_ctrl: directed table, corner sequences, random vs queue model.
module tb_duart_rx_channel_ctrl;
  localparam int DEPTH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  duart_rx_channel_ctrl_if bus();

  duart_rx_channel_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .i_Clock (clk),
    .i_Rst_L (rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic       dv;
    logic [7:0] b;
    logic [1:0] rxen;
    logic [2:0] misc;
    logic       wr;
    logic       rd;
    logic       sel;
    logic       e_rdy;
    logic       e_full;
    logic       e_ovr;
    logic       e_en;
    logic       e_irq;
    logic       chkd;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state
  logic [7:0] mq[$];
  logic       m_en;
  logic       m_ovr;
  int         m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic dv, input logic [7:0] b, input logic [1:0] rxen,
                       input logic [2:0] misc, input logic wr, input logic rd, input logic sel);
    @(negedge clk);
    bus.i_RX_DV        = dv;
    bus.i_RX_Byte      = b;
    bus.i_Rx_En_Cmd    = rxen;
    bus.i_Misc_Cmd     = misc;
    bus.i_Cmd_Wr       = wr;
    bus.i_Rd_Strobe    = rd;
    bus.i_Irq_Sel_Full = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 8'h00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic vec_t mk(input logic dv, input logic [7:0] b, input logic [1:0] rxen,
                              input logic [2:0] misc, input logic wr, input logic rd, input logic sel,
                              input logic e_rdy, input logic e_full, input logic e_ovr,
                              input logic e_en, input logic e_irq, input logic chkd,
                              input logic [7:0] e_data);
    vec_t v;
    v.dv = dv; v.b = b; v.rxen = rxen; v.misc = misc; v.wr = wr; v.rd = rd; v.sel = sel;
    v.e_rdy = e_rdy; v.e_full = e_full; v.e_ovr = e_ovr; v.e_en = e_en; v.e_irq = e_irq;
    v.chkd = chkd; v.e_data = e_data;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_RX_DV = 0; bus.i_RX_Byte = 0; bus.i_Rx_En_Cmd = 0; bus.i_Misc_Cmd = 0;
    bus.i_Cmd_Wr = 0; bus.i_Rd_Strobe = 0; bus.i_Irq_Sel_Full = 0;
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); m_en = 0; m_ovr = 0; m_cnt = 0;
  endtask

  // Reference model step: apply one cycle of the channel rules to the queue model.
  task automatic model_step(input logic dv, input logic [7:0] b, input logic [1:0] rxen,
                            input logic [2:0] misc, input logic wr, input logic rd);
    bit do_pop, do_push, ovr_ev;
    if (wr && misc == 3'b010) begin
      mq.delete(); m_en = 0; m_ovr = 0; m_cnt = 0;
      return;
    end
    do_pop  = rd && (mq.size() > 0);
    do_push = dv && m_en && ((mq.size() - int'(do_pop)) < DEPTH);
    ovr_ev  = dv && m_en && !do_push;
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(b);
    if (wr && misc == 3'b100) begin
      m_ovr = 0;
      m_cnt = 0;
    end
    if (ovr_ev) begin
      m_ovr = 1;
      if (m_cnt < 255) m_cnt++;
    end
    if (wr && rxen == 2'b01) m_en = 1;
    if (wr && rxen == 2'b10) m_en = 0;
  endtask

  initial begin
    bus.i_RX_DV = 0; bus.i_RX_Byte = 0; bus.i_Rx_En_Cmd = 0; bus.i_Misc_Cmd = 0;
    bus.i_Cmd_Wr = 0; bus.i_Rd_Strobe = 0; bus.i_Irq_Sel_Full = 0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_rdy",  bus.o_RxRDY, 0);
    chk("rst_full", bus.o_FFULL, 0);
    chk("rst_ovr",  bus.o_Overrun, 0);
    chk("rst_en",   bus.o_Rx_Enabled, 0);
    chk("rst_irq",  bus.o_Rx_Irq, 0);
    chk("rst_data", bus.o_Rx_Data, 8'h00);
`ifdef DUART_RX_OVR_COUNT_EN
    chk("rst_ocnt", bus.o_Ovr_Count, 8'h00);
`endif
    rst_n = 1'b1;

    //            dv b     rxen   misc    wr rd sel  rdy full ovr en irq chkd data
    tbl.push_back(mk(0, 8'h00, 2'b01, 3'b000, 1, 0, 0,  0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'hA5, 2'b00, 3'b000, 0, 0, 0,  1, 0, 0, 1, 1, 1, 8'hA5));
    tbl.push_back(mk(0, 8'h00, 2'b00, 3'b000, 0, 1, 0,  0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'h11, 2'b00, 3'b000, 0, 0, 0,  1, 0, 0, 1, 1, 1, 8'h11));
    tbl.push_back(mk(1, 8'h22, 2'b00, 3'b000, 0, 0, 0,  1, 0, 0, 1, 1, 1, 8'h11));
    tbl.push_back(mk(1, 8'h33, 2'b00, 3'b000, 0, 0, 1,  1, 1, 0, 1, 1, 1, 8'h11));
    tbl.push_back(mk(1, 8'h44, 2'b00, 3'b000, 0, 0, 1,  1, 1, 1, 1, 1, 1, 8'h11));
    tbl.push_back(mk(1, 8'h55, 2'b00, 3'b000, 0, 1, 1,  1, 1, 1, 1, 1, 1, 8'h22));
    tbl.push_back(mk(0, 8'h00, 2'b00, 3'b100, 1, 0, 1,  1, 1, 0, 1, 1, 1, 8'h22));
    tbl.push_back(mk(0, 8'h00, 2'b00, 3'b000, 0, 1, 1,  1, 0, 0, 1, 0, 1, 8'h33));
    tbl.push_back(mk(0, 8'h00, 2'b00, 3'b000, 0, 1, 0,  1, 0, 0, 1, 1, 1, 8'h55));
    tbl.push_back(mk(0, 8'h00, 2'b10, 3'b000, 1, 0, 0,  1, 0, 0, 0, 1, 1, 8'h55));
    tbl.push_back(mk(1, 8'h77, 2'b00, 3'b000, 0, 0, 0,  1, 0, 0, 0, 1, 1, 8'h55));
    tbl.push_back(mk(0, 8'h00, 2'b00, 3'b000, 0, 1, 0,  0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 2'b01, 3'b000, 1, 0, 0,  0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'h01, 2'b00, 3'b000, 0, 0, 0,  1, 0, 0, 1, 1, 1, 8'h01));
    tbl.push_back(mk(1, 8'h02, 2'b00, 3'b000, 0, 0, 0,  1, 0, 0, 1, 1, 1, 8'h01));
    tbl.push_back(mk(1, 8'h03, 2'b01, 3'b010, 1, 1, 0,  0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 2'b01, 3'b000, 1, 0, 0,  0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'h0A, 2'b00, 3'b000, 0, 0, 0,  1, 0, 0, 1, 1, 1, 8'h0A));
    tbl.push_back(mk(1, 8'h0B, 2'b00, 3'b000, 0, 0, 0,  1, 0, 0, 1, 1, 1, 8'h0A));
    tbl.push_back(mk(1, 8'h0C, 2'b00, 3'b000, 0, 0, 0,  1, 1, 0, 1, 1, 1, 8'h0A));
    tbl.push_back(mk(1, 8'h0D, 2'b00, 3'b100, 1, 0, 0,  1, 1, 1, 1, 1, 1, 8'h0A));
    tbl.push_back(mk(0, 8'h00, 2'b00, 3'b010, 1, 0, 0,  0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 2'b00, 3'b000, 0, 1, 0,  0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 2'b01, 3'b000, 1, 0, 0,  0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'h0E, 2'b00, 3'b000, 0, 1, 0,  1, 0, 0, 1, 1, 1, 8'h0E));
    tbl.push_back(mk(1, 8'h0F, 2'b10, 3'b000, 1, 0, 0,  1, 0, 0, 0, 1, 1, 8'h0E));
    tbl.push_back(mk(0, 8'h00, 2'b00, 3'b000, 0, 1, 0,  1, 0, 0, 0, 1, 1, 8'h0F));
    tbl.push_back(mk(0, 8'h00, 2'b00, 3'b000, 0, 1, 0,  0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'h99, 2'b01, 3'b000, 1, 0, 0,  0, 0, 0, 1, 0, 0, 8'h00));

    foreach (tbl[i]) begin
      apply(tbl[i].dv, tbl[i].b, tbl[i].rxen, tbl[i].misc, tbl[i].wr, tbl[i].rd, tbl[i].sel);
      chk($sformatf("tbl%0d_rdy", i),  bus.o_RxRDY,      tbl[i].e_rdy);
      chk($sformatf("tbl%0d_full", i), bus.o_FFULL,      tbl[i].e_full);
      chk($sformatf("tbl%0d_ovr", i),  bus.o_Overrun,    tbl[i].e_ovr);
      chk($sformatf("tbl%0d_en", i),   bus.o_Rx_Enabled, tbl[i].e_en);
      chk($sformatf("tbl%0d_irq", i),  bus.o_Rx_Irq,     tbl[i].e_irq);
      if (tbl[i].chkd) chk($sformatf("tbl%0d_data", i), bus.o_Rx_Data, tbl[i].e_data);
    end

    // Asynchronous reset mid-fill with two bytes buffered
    do_reset();
    apply(0, 8'h00, 2'b01, 3'b000, 1, 0, 0);
    apply(1, 8'hC1, 2'b00, 3'b000, 0, 0, 0);
    apply(1, 8'hC2, 2'b00, 3'b000, 0, 0, 0);
    chk("pre_arst_rdy", bus.o_RxRDY, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdy",  bus.o_RxRDY, 0);
    chk("arst_data", bus.o_Rx_Data, 8'h00);
    chk("arst_en",   bus.o_Rx_Enabled, 0);
    chk("arst_full", bus.o_FFULL, 0);
    chk("arst_ovr",  bus.o_Overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DUART_RX_OVR_COUNT_EN
    // Saturating overrun counter
    apply(0, 8'h00, 2'b01, 3'b000, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) apply(1, 8'(i), 2'b00, 3'b000, 0, 0, 0);
    for (int i = 0; i < 300; i++) apply(1, 8'hEE, 2'b00, 3'b000, 0, 0, 0);
    chk("ocnt_sat", bus.o_Ovr_Count, 8'hFF);
    apply(0, 8'h00, 2'b00, 3'b100, 1, 0, 0);
    chk("ocnt_clr", bus.o_Ovr_Count, 8'h00);
`endif

    // Randomized run against the queue model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic       dv, wr, rd, sel;
      logic [7:0] b;
      logic [1:0] rxen;
      logic [2:0] misc;
      int         r;
      dv   = ($urandom_range(0, 3) != 0);
      b    = 8'($urandom);
      rd   = ($urandom_range(0, 2) == 0);
      wr   = ($urandom_range(0, 5) == 0);
      rxen = 2'($urandom);
      sel  = 1'($urandom);
      r    = $urandom_range(0, 9);
      misc = (r == 0) ? 3'b010 : (r < 3) ? 3'b100 : 3'($urandom_range(0, 1));
      apply(dv, b, rxen, misc, wr, rd, sel);
      model_step(dv, b, rxen, misc, wr, rd);
      chk("rnd_rdy",  bus.o_RxRDY,      (mq.size() != 0));
      chk("rnd_full", bus.o_FFULL,      (mq.size() == DEPTH));
      chk("rnd_ovr",  bus.o_Overrun,    m_ovr);
      chk("rnd_en",   bus.o_Rx_Enabled, m_en);
      chk("rnd_irq",  bus.o_Rx_Irq,     sel ? (mq.size() == DEPTH) : (mq.size() != 0));
      if (mq.size() != 0) chk("rnd_data", bus.o_Rx_Data, mq[0]);
`ifdef DUART_RX_OVR_COUNT_EN
      chk("rnd_ocnt", bus.o_Ovr_Count, m_cnt);
`endif
    end

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
